// File: rtl/cic_comp_pkg.sv
// Shared types and helpers for the CIC compensation FIR.
package cic_comp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      ROUND = 2'd2
   } fir_state_t;

   // Accumulator width: full product width plus headroom for summing every tap.
   function automatic int acc_width(input int inp_dw, input int coef_w, input int ntaps);
      return inp_dw + coef_w + $clog2(ntaps);
   endfunction

endpackage

// File: rtl/cic_comp_ring.sv
// Circular sample history for the compensation FIR.
// Writes land at a wrapping pointer; reads are addressed by tap age,
// where tap 0 is the most recently written sample.
module cic_comp_ring #(
   parameter int DW    = 18,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic signed [DW-1:0]     wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_tap,
   output logic signed [DW-1:0]     rd_data
);

   localparam int AW = $clog2(DEPTH);

   logic signed [DW-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW:0]          rd_sum;
   logic [AW-1:0]        rd_idx;

   // Store the new sample and advance the pointer, wrapping after DEPTH-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_ptr] <= wr_data;
         if (wr_ptr == AW'(DEPTH - 1)) begin
            wr_ptr <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(1);
         end
      end
   end

   // Map tap age to a slot: newest sample sits one behind the write pointer.
   always_comb begin
      rd_sum = {1'b0, wr_ptr} + (AW+1)'(DEPTH - 1) - {1'b0, rd_tap};
      if (rd_sum >= (AW+1)'(DEPTH)) begin
         rd_idx = AW'(rd_sum - (AW+1)'(DEPTH));
      end else begin
         rd_idx = rd_sum[AW-1:0];
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC compensation FIR placed after a CIC decimator.
// One multiply-accumulate per cycle; the product is registered before
// accumulation, so the last product is folded in during ROUND and the
// rounded, saturated result is registered on the following edge.
module cic_comp_fir
   import cic_comp_pkg::*;
#(
   parameter int                      INP_DW    = 18,
   parameter int                      OUT_DW    = 18,
   parameter int                      COEF_W    = 18,
   parameter int                      COEF_FRAC = 16,
   parameter int                      NTAPS     = 16,
   parameter int                      DEC       = 1,
   parameter logic [NTAPS*COEF_W-1:0] COEFS     = '0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic signed [INP_DW-1:0] inp_samp_data,
   input  logic                     inp_samp_str,
   output logic signed [OUT_DW-1:0] out_samp_data,
   output logic                     out_samp_str,
   output logic                     overrun
);

   localparam int ACC_W  = acc_width(INP_DW, COEF_W, NTAPS);
   localparam int PROD_W = INP_DW + COEF_W;
   localparam int TAP_W  = $clog2(NTAPS);

   localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (COEF_FRAC - 1);
   localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((longint'(1) << (OUT_DW - 1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN  = -SAT_MAX - 1;

   fir_state_t               state;
   logic [TAP_W-1:0]         tap;
   logic                     phase;
   logic signed [ACC_W-1:0]  acc;
   logic signed [PROD_W-1:0] prod;
   logic                     out_pend;

   logic                     accept;
   logic                     start;
   logic signed [INP_DW-1:0] tap_samp;
   logic signed [COEF_W-1:0] tap_coef;
   logic signed [PROD_W-1:0] samp_ext;
   logic signed [PROD_W-1:0] coef_ext;
   logic signed [PROD_W-1:0] mult;
   logic signed [ACC_W:0]    rnd_sum;
   logic signed [ACC_W:0]    rnd_shift;
   logic signed [OUT_DW-1:0] sat_data;

   // Samples are only taken while idle; with DEC=2 every other one starts a run.
   assign accept = inp_samp_str && (state == IDLE);
   assign start  = accept && !phase;

   cic_comp_ring #(
      .DW    (INP_DW),
      .DEPTH (NTAPS)
   ) u_ring (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (accept),
      .wr_data (inp_samp_data),
      .rd_tap  (tap),
      .rd_data (tap_samp)
   );

   // Multiply the aged sample by its coefficient at full precision.
   always_comb begin
      tap_coef = COEFS[COEF_W*tap +: COEF_W];
      samp_ext = PROD_W'(tap_samp);
      coef_ext = PROD_W'(tap_coef);
      mult     = samp_ext * coef_ext;
   end

   // Round half up, drop the fractional bits, and clamp to the output range.
   always_comb begin
      rnd_sum   = (ACC_W+1)'(acc) + RND_HALF;
      rnd_shift = rnd_sum >>> COEF_FRAC;
      if (rnd_shift > SAT_MAX) begin
         sat_data = SAT_MAX[OUT_DW-1:0];
      end else if (rnd_shift < SAT_MIN) begin
         sat_data = SAT_MIN[OUT_DW-1:0];
      end else begin
         sat_data = rnd_shift[OUT_DW-1:0];
      end
   end

   // Sequence IDLE -> MAC (NTAPS cycles) -> ROUND, then publish the result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         tap           <= '0;
         phase         <= 1'b0;
         acc           <= '0;
         prod          <= '0;
         out_pend      <= 1'b0;
         out_samp_data <= '0;
         out_samp_str  <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         overrun      <= inp_samp_str && (state != IDLE);
         out_samp_str <= out_pend;
         out_pend     <= 1'b0;
         if (out_pend) begin
            out_samp_data <= sat_data;
         end
         if (accept) begin
            phase <= (DEC == 2) ? ~phase : 1'b0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state <= MAC;
                  tap   <= '0;
                  acc   <= '0;
                  prod  <= '0;
               end
            end
            MAC: begin
               prod <= mult;
               acc  <= acc + ACC_W'(prod);
               if (tap == TAP_W'(NTAPS - 1)) begin
                  state <= ROUND;
               end else begin
                  tap <= tap + TAP_W'(1);
               end
            end
            ROUND: begin
               acc      <= acc + ACC_W'(prod);
               out_pend <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: three 4-tap instances
// (A: taps 1.0/0.5/0.25/0, B: all taps 1.0, C: A's taps with DEC=2)
// checked every cycle against a sample-history model, plus literal pins.
module tb_cic_comp_fir;

   localparam int NT = 4;

   logic clk;
   logic reset_n;

   logic signed [17:0] din_a, din_b, din_c;
   logic               str_a, str_b, str_c;
   logic signed [17:0] dout_a, dout_b, dout_c;
   logic               ostr_a, ostr_b, ostr_c;
   logic               ovr_a, ovr_b, ovr_c;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int     coef_tab [3][NT] = '{'{65536, 32768, 16384, 0},
                                '{65536, 65536, 65536, 65536},
                                '{65536, 32768, 16384, 0}};
   int     dec_tab  [3]     = '{1, 1, 2};
   int     hist     [3][NT];
   int     phase_m  [3];
   longint busy_until [3];
   longint pend_due [3];
   int     pend_val [3];
   logic   pend_vld [3];
   int     last_out [3];
   int     rec      [3][32];
   int     rec_cnt  [3] = '{0, 0, 0};
   int     ovr_cnt  [3] = '{0, 0, 0};
   int     imp_exp  [4] = '{1000, 500, 250, 0};

   cic_comp_fir #(
      .INP_DW(18), .OUT_DW(18), .COEF_W(18), .COEF_FRAC(16), .NTAPS(4), .DEC(1),
      .COEFS({18'd0, 18'd16384, 18'd32768, 18'd65536})
   ) dut_a (
      .clk(clk), .reset_n(reset_n),
      .inp_samp_data(din_a), .inp_samp_str(str_a),
      .out_samp_data(dout_a), .out_samp_str(ostr_a), .overrun(ovr_a)
   );

   cic_comp_fir #(
      .INP_DW(18), .OUT_DW(18), .COEF_W(18), .COEF_FRAC(16), .NTAPS(4), .DEC(1),
      .COEFS({18'd65536, 18'd65536, 18'd65536, 18'd65536})
   ) dut_b (
      .clk(clk), .reset_n(reset_n),
      .inp_samp_data(din_b), .inp_samp_str(str_b),
      .out_samp_data(dout_b), .out_samp_str(ostr_b), .overrun(ovr_b)
   );

   cic_comp_fir #(
      .INP_DW(18), .OUT_DW(18), .COEF_W(18), .COEF_FRAC(16), .NTAPS(4), .DEC(2),
      .COEFS({18'd0, 18'd16384, 18'd32768, 18'd65536})
   ) dut_c (
      .clk(clk), .reset_n(reset_n),
      .inp_samp_data(din_c), .inp_samp_str(str_c),
      .out_samp_data(dout_c), .out_samp_str(ostr_c), .overrun(ovr_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int satRound(input longint y);
      longint r;
      r = (y + 64'sd32768) >>> 16;
      if (r > 131071) r = 131071;
      else if (r < -131072) r = -131072;
      return int'(r);
   endfunction

   // Model: a strobe within NTAPS+1 edges of a start is dropped as overrun;
   // otherwise it joins the history, and on phase 0 the FIR sum appears
   // NTAPS+2 edges later. Output data holds between strobes.
   task automatic stepModel(input int id, input string nm, input logic s, input int d,
                            input int q, input logic qs, input logic qo);
      logic   exp_str;
      logic   exp_ovr;
      longint y;
      exp_str = 1'b0;
      exp_ovr = 1'b0;
      if (!reset_n) begin
         for (int t = 0; t < NT; t++) hist[id][t] = 0;
         phase_m[id]    = 0;
         busy_until[id] = -1;
         pend_vld[id]   = 1'b0;
         last_out[id]   = 0;
      end else begin
         if (pend_vld[id] && pend_due[id] == longint'(cyc)) begin
            exp_str      = 1'b1;
            last_out[id] = pend_val[id];
            pend_vld[id] = 1'b0;
         end
         if (s) begin
            if (longint'(cyc) <= busy_until[id]) begin
               exp_ovr = 1'b1;
            end else begin
               for (int t = NT - 1; t > 0; t--) hist[id][t] = hist[id][t-1];
               hist[id][0] = d;
               if (phase_m[id] == 0) begin
                  y = 0;
                  for (int t = 0; t < NT; t++) y += longint'(hist[id][t]) * longint'(coef_tab[id][t]);
                  pend_val[id]   = satRound(y);
                  pend_due[id]   = cyc + NT + 2;
                  pend_vld[id]   = 1'b1;
                  busy_until[id] = cyc + NT + 1;
               end
               phase_m[id] = (phase_m[id] + 1) % dec_tab[id];
            end
         end
      end
      if (qs) begin
         if (rec_cnt[id] < 32) rec[id][rec_cnt[id]] = q;
         rec_cnt[id]++;
      end
      if (qo) ovr_cnt[id]++;
      checkOutput({nm, "_str"}, longint'(qs), longint'(exp_str));
      checkOutput({nm, "_ovr"}, longint'(qo), longint'(exp_ovr));
      checkOutput({nm, "_dout"}, longint'(q), longint'(last_out[id]));
   endtask

   // Compare every instance against the model just after each rising edge.
   always @(posedge clk) begin
      #1;
      stepModel(0, "a", str_a, int'(din_a), int'(dout_a), ostr_a, ovr_a);
      stepModel(1, "b", str_b, int'(din_b), int'(dout_b), ostr_b, ovr_b);
      stepModel(2, "c", str_c, int'(din_c), int'(dout_c), ostr_c, ovr_c);
      cyc++;
   end

   task automatic applyStimulus(input int id, input int d, input int gap);
      case (id)
         0: begin din_a = 18'(d); str_a = 1'b1; end
         1: begin din_b = 18'(d); str_b = 1'b1; end
         default: begin din_c = 18'(d); str_c = 1'b1; end
      endcase
      @(negedge clk);
      str_a = 1'b0;
      str_b = 1'b0;
      str_c = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   initial begin
      int base;
      int obase;
      reset_n = 1'b1;
      str_a = 1'b0; str_b = 1'b0; str_c = 1'b0;
      din_a = '0;   din_b = '0;   din_c = '0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_dout_a", longint'(dout_a), 0);
      checkOutput("reset_str_a", longint'(ostr_a), 0);

      $display("[TB] impulse response");
      base = rec_cnt[0];
      applyStimulus(0, 1000, 10);
      repeat (3) applyStimulus(0, 0, 10);
      checkOutput("impulse_count", rec_cnt[0] - base, 4);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("impulse_y%0d", i), rec[0][base+i], imp_exp[i]);

      $display("[TB] rounding");
      base = rec_cnt[0];
      applyStimulus(0, 3, 10);
      repeat (3) applyStimulus(0, 0, 10);
      applyStimulus(0, -3, 10);
      repeat (3) applyStimulus(0, 0, 10);
      checkOutput("round_pos_half", rec[0][base+1], 2);
      checkOutput("round_neg_half", rec[0][base+5], -1);

      $display("[TB] overrun");
      base  = rec_cnt[0];
      obase = ovr_cnt[0];
      applyStimulus(0, 500, 2);
      applyStimulus(0, 7777, 12);
      checkOutput("overrun_pulses", ovr_cnt[0] - obase, 1);
      checkOutput("overrun_out_count", rec_cnt[0] - base, 1);
      checkOutput("overrun_result", rec[0][base], 500);

      $display("[TB] reset mid-MAC");
      base  = rec_cnt[0];
      din_a = 18'sd1000;
      str_a = 1'b1;
      @(negedge clk);
      str_a = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("reset_async_dout", longint'(dout_a), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("reset_no_output", rec_cnt[0] - base, 0);
      applyStimulus(0, 1000, 10);
      repeat (3) applyStimulus(0, 0, 10);
      checkOutput("post_reset_count", rec_cnt[0] - base, 4);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("post_reset_y%0d", i), rec[0][base+i], imp_exp[i]);

      $display("[TB] saturation");
      base = rec_cnt[1];
      repeat (4) applyStimulus(1, 131071, 10);
      repeat (4) applyStimulus(1, -131072, 10);
      checkOutput("sat_pos", rec[1][base+3], 131071);
      checkOutput("sat_mixed", rec[1][base+5], -2);
      checkOutput("sat_neg", rec[1][base+7], -131072);

      $display("[TB] decimate by 2");
      base = rec_cnt[2];
      for (int i = 1; i <= 8; i++) applyStimulus(2, 100 * i, 8);
      repeat (4) @(negedge clk);
      checkOutput("dec2_count", rec_cnt[2] - base, 4);
      checkOutput("dec2_first", rec[2][base], 100);
      checkOutput("dec2_second", rec[2][base+1], 425);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
